lsu_mem_bridge: RTL

LSU_MEM_BRIDGE -- requirements
Module: lsu_mem_bridge

---
 rtl/lsu_mem_bridge.sv | 84 ++++++++
 1 files changed

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: arbitrates LSU load/store requests onto a single-outstanding cache request/response bus with timeout.
module lsu_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                load_req_i,
  input  logic [ADDR_W-1:0]   load_addr_i,
  output logic [DATA_W-1:0]   load_data_o,
  output logic                load_complete_o,
  input  logic                store_req_i,
  input  logic [ADDR_W-1:0]   store_addr_i,
  input  logic [DATA_W-1:0]   store_data_i,
  output logic                store_complete_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_rvalid_i,
  output logic                err_o
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, CPL} state_t;
  state_t state, state_nx;
  logic last_store, is_load, err_q;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] data_q, rdata_q;
  logic [15:0] cnt;
  logic grant, pick_load, waiting, expire, capture, done, timeout;
  assign pick_load = load_req_i && (!store_req_i || last_store);
  assign grant     = (state == IDLE) && (load_req_i || store_req_i);
  assign sel_addr  = pick_load ? load_addr_i : store_addr_i;
  assign waiting   = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
  assign expire    = waiting && (cnt >= 16'(TIMEOUT - 1));
  assign capture   = ((state == RD_REQ) && iob_ready_i && iob_rvalid_i) || ((state == RD_WAIT) && iob_rvalid_i);
  // an accepted read that still awaits data is progress, not a timeout
  assign done      = capture || ((state == WR_REQ) && iob_ready_i) || ((state == RD_REQ) && iob_ready_i);
  assign timeout   = expire && !done;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = grant ? (pick_load ? RD_REQ : WR_REQ) : IDLE;
      RD_REQ:  state_nx = iob_ready_i ? (iob_rvalid_i ? CPL : RD_WAIT) : (expire ? CPL : RD_REQ);
      RD_WAIT: state_nx = (capture || expire) ? CPL : RD_WAIT;
      WR_REQ:  state_nx = (iob_ready_i || expire) ? CPL : WR_REQ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= IDLE;
      last_store <= 1'b1;
      is_load    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= timeout;
      cnt   <= waiting ? cnt + 16'd1 : 16'd0;
      if (grant) begin
        last_store <= !pick_load;
        is_load    <= pick_load;
        addr_q     <= {sel_addr[ADDR_W-1:2], 2'b00};
        if (!pick_load) data_q <= store_data_i;
      end
      if (capture) rdata_q <= iob_rdata_i;
      else if (timeout && is_load) rdata_q <= '0;
    end
  end
  assign iob_valid_o      = (state == RD_REQ) || (state == WR_REQ);
  assign iob_addr_o       = addr_q;
  assign iob_wdata_o      = data_q;
  assign iob_wstrb_o      = (state == WR_REQ) ? '1 : '0;
  assign load_data_o      = rdata_q;
  assign load_complete_o  = (state == CPL) && is_load;
  assign store_complete_o = (state == CPL) && !is_load;
  assign err_o            = err_q;
endmodule
